clk_div_scheduler: RTL and testbench
====================================

// Module: clk_div_scheduler
// PURPOSE
//  - Shared timebase for the board. One prescaler divides clk_i into a base tick.
//  - NCH independent channels divide the base tick by runtime-programmable divisors.
//  - Each channel drives a one-cycle tick enable and a 50% square wave.
//  - Replaces per-consumer free-running dividers (display scan, blink, debounce)
//    with one configured, phase-controlled scheduler.
// PARAMETERS
//  BASE_DIV  50000  clk_i cycles per base tick (>=2); 100 MHz -> 2 kHz base
//  NCH       4      number of channels (1..16)
//  CW        16     channel divisor width in bits
// PORTS
//  clk_i        in   1              system clock
//  rst_i        in   1              reset, asynchronous, active-low
//  cfg_valid_i  in   1              config request valid
//  cfg_ready_o  out  1              config request accepted when valid&ready
//  cfg_ch_i     in   $clog2(NCH)>0?$clog2(NCH):1  target channel index
//  cfg_div_i    in   CW             channel divisor in base ticks; 0 = disable
//  base_tick_o  out  1              one-cycle pulse, once per BASE_DIV clk_i
//  tick_o       out  NCH            per-channel one-cycle tick enable
//  sq_o         out  NCH            per-channel square wave, toggles on each tick
// BEHAVIOUR
//  Reset (async, rst_i=0):
//   - prescaler=0, all channel counters=0, all div=0 (disabled).
//   - base_tick_o=0, tick_o=0, sq_o=0, cfg_ready_o=1, FSM=IDLE.
//   - Reset mid-operation aborts any pending config; nothing is applied.
//  Prescaler:
//   - Counts 0..BASE_DIV-1 and wraps.
//   - base_tick_o is registered: high for exactly the cycle after count==BASE_DIV-1.
//   - First pulse at the BASE_DIV-th rising edge after reset release; period BASE_DIV.
//  Channel k (advances only on cycles with base_tick_o=1):
//   - div==0: counter held 0, tick_o[k]=0, sq_o[k] held 0.
//   - cnt==div-1: cnt<=0, tick_o[k]<=1 (next cycle, one cycle wide), sq_o[k] toggles.
//   - Otherwise cnt<=cnt+1.
//   - tick_o[k] period = div*BASE_DIV clk; sq_o[k] period = 2*div*BASE_DIV clk.
//   - div==1: tick one cycle after every base_tick_o.
//  Config FSM (IDLE, PEND):
//   - IDLE: cfg_ready_o=1. On cfg_valid_i&cfg_ready_o, latch ch/div -> PEND, ready<=0.
//   - PEND: cfg_ready_o=0. On the next cycle with base_tick_o=1, apply to target:
//     div<=new, cnt<=0, sq<=0; that channel emits no tick that cycle.
//     Then -> IDLE.
//   - Other channels are never disturbed by a config.
//   - Requester holds valid/ch/div stable until accepted; no request is dropped.
//   - cfg_ch_i>=NCH: handshake completes normally, no channel changes.
//   - First tick after apply: div base ticks later (phase restarts at apply).
// CONFIGURATION
//  DIV_SCHED_IMMEDIATE_EN
//   - Undefined: config applied at a base-tick boundary (PEND wait, up to BASE_DIV clk).
//   - Defined: config applied on the cycle after acceptance, regardless of base_tick_o.
//     PEND lasts exactly 1 cycle; cfg_ready_o low 1 cycle; channel reset rules unchanged.
// TESTING (BASE_DIV=4, NCH=4, CW=8)
//  - Reset release, no config -> base_tick_o every 4 clk, first at edge 4;
//    tick_o=0, sq_o=0 throughout.
//  - cfg ch1 div=3 -> after apply, tick_o[1] every 12 clk, first 12 clk after apply;
//    sq_o[1] period 24 clk; other channels stay 0.
//  - cfg ch0 div=1 and ch2 div=2 back-to-back (valid held) -> second accepted only
//    after first applied; tick_o[0] every 4 clk, tick_o[2] every 8 clk.
//  - Running ch1 div=3, reprogram div=0 -> tick_o[1]/sq_o[1] go 0 at apply
//    and stay 0; ch0 phase unchanged.
//  - Assert rst_i=0 while FSM in PEND -> outputs 0 immediately,
//    cfg_ready_o=1 after release, pending config not applied.
//  - With DIV_SCHED_IMMEDIATE_EN: cfg ch3 div=2 -> cfg_ready_o low exactly 1 cycle,
//    counter cleared that cycle, tick_o[3] on the 2nd following base tick.

Source files
------------

// File: rtl/clk_div_scheduler.sv
// Shared timebase: one prescaler plus NCH programmable tick/square-wave channels.
// Optional macro DIV_SCHED_IMMEDIATE_EN applies configs without waiting for a base tick.
module clk_div_scheduler #(
   parameter int BASE_DIV = 50000,
   parameter int NCH      = 4,
   parameter int CW       = 16
) (
   input  logic                                  clk_i,
   input  logic                                  rst_i,
   input  logic                                  cfg_valid_i,
   output logic                                  cfg_ready_o,
   input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch_i,
   input  logic [CW-1:0]                         cfg_div_i,
   output logic                                  base_tick_o,
   output logic [NCH-1:0]                        tick_o,
   output logic [NCH-1:0]                        sq_o
);

   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW  = $clog2(BASE_DIV);

   typedef enum logic {IDLE, PEND} state_t;

   state_t               state_q, state_d;
   logic [PW-1:0]        pre_q, pre_d;
   logic                 base_tick_q, base_tick_d;
   logic [CHW-1:0]       ch_q, ch_d;
   logic [CW-1:0]        ndiv_q, ndiv_d;
   logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
   logic [NCH-1:0][CW-1:0] div_q, div_d;
   logic [NCH-1:0]       tick_q, tick_d;
   logic [NCH-1:0]       sq_q, sq_d;
   logic                 apply_ok;
   logic                 apply;

`ifdef DIV_SCHED_IMMEDIATE_EN
   assign apply_ok = 1'b1;
`else
   assign apply_ok = base_tick_q;
`endif

   assign cfg_ready_o = (state_q == IDLE);
   assign base_tick_o = base_tick_q;
   assign tick_o      = tick_q;
   assign sq_o        = sq_q;

   always_comb begin
      pre_d       = (pre_q == PW'(BASE_DIV - 1)) ? '0 : pre_q + 1'b1;
      base_tick_d = (pre_q == PW'(BASE_DIV - 1));
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      ndiv_d  = ndiv_q;
      apply   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cfg_valid_i) begin
               state_d = PEND;
               ch_d    = cfg_ch_i;
               ndiv_d  = cfg_div_i;
            end
         end
         PEND: begin
            if (apply_ok) begin
               apply   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // An apply to a channel overrides that channel's own advance on the same cycle.
   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      sq_d   = sq_q;
      tick_d = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (apply && (ch_q == CHW'(k))) begin
            div_d[k] = ndiv_q;
            cnt_d[k] = '0;
            sq_d[k]  = 1'b0;
         end else if (base_tick_q) begin
            if (div_q[k] == '0) begin
               cnt_d[k] = '0;
               sq_d[k]  = 1'b0;
            end else if (cnt_q[k] == div_q[k] - CW'(1)) begin
               cnt_d[k]  = '0;
               tick_d[k] = 1'b1;
               sq_d[k]   = ~sq_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= IDLE;
         pre_q       <= '0;
         base_tick_q <= 1'b0;
         ch_q        <= '0;
         ndiv_q      <= '0;
         cnt_q       <= '0;
         div_q       <= '0;
         tick_q      <= '0;
         sq_q        <= '0;
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         base_tick_q <= base_tick_d;
         ch_q        <= ch_d;
         ndiv_q      <= ndiv_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         tick_q      <= tick_d;
         sq_q        <= sq_d;
      end
   end

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Bench for clk_div_scheduler (BASE_DIV=4, NCH=4, CW=8): per-cycle scoreboard
// against an edge-count model of base ticks and per-channel tick counts.
module tb_clk_div_scheduler;

   localparam int BD  = 4;
   localparam int NCH = 4;
   localparam int CW  = 8;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b0;
   logic          cfg_valid_i = 1'b0;
   logic          cfg_ready_o;
   logic [1:0]    cfg_ch_i = '0;
   logic [CW-1:0] cfg_div_i = '0;
   logic          base_tick_o;
   logic [NCH-1:0] tick_o;
   logic [NCH-1:0] sq_o;

   clk_div_scheduler #(.BASE_DIV(BD), .NCH(NCH), .CW(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
      .cfg_ch_i(cfg_ch_i), .cfg_div_i(cfg_div_i), .base_tick_o(base_tick_o),
      .tick_o(tick_o), .sq_o(sq_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic           bt;
      logic           rdy;
      logic [NCH-1:0] tick;
      logic [NCH-1:0] sq;
   } exp_t;

   exp_t expq[$];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic check(input string nm, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Reference model: time measured in clock edges since reset release.
   int  e;
   bit  m_pend;
   int  m_ch, m_ndiv;
   int  m_div[NCH];
   int  nb[NCH];
   int  tc[NCH];

   always @(posedge clk_i or negedge rst_i) begin
      exp_t x;
      bit   bt_prev, apply, accept;
      if (!rst_i) begin
         e = 0;
         m_pend = 0;
         for (int k = 0; k < NCH; k++) begin
            m_div[k] = 0; nb[k] = 0; tc[k] = 0;
         end
         expq.delete();
      end else begin
         bt_prev = (e > 0) && (e % BD == 0);
         e++;
`ifdef DIV_SCHED_IMMEDIATE_EN
         apply = m_pend;
`else
         apply = m_pend && bt_prev;
`endif
         accept = !m_pend && cfg_valid_i;
         x.tick = '0;
         for (int k = 0; k < NCH; k++) begin
            if (apply && m_ch == k) begin
               m_div[k] = m_ndiv; nb[k] = 0; tc[k] = 0;
            end else if (bt_prev && m_div[k] != 0) begin
               nb[k]++;
               if (nb[k] % m_div[k] == 0) begin
                  x.tick[k] = 1'b1;
                  tc[k]++;
               end
            end
         end
         if (apply) m_pend = 0;
         if (accept) begin
            m_pend = 1; m_ch = int'(cfg_ch_i); m_ndiv = int'(cfg_div_i);
         end
         x.bt  = (e % BD == 0);
         x.rdy = !m_pend;
         for (int k = 0; k < NCH; k++) x.sq[k] = tc[k][0];
         expq.push_back(x);
      end
   end

   always @(negedge clk_i) begin
      exp_t x;
      if (!rst_i) begin
         check("rst_base_tick", int'(base_tick_o), 0);
         check("rst_tick", int'(tick_o), 0);
         check("rst_sq", int'(sq_o), 0);
         check("rst_ready", int'(cfg_ready_o), 1);
      end else if (expq.size() > 0) begin
         x = expq.pop_front();
         check("base_tick", int'(base_tick_o), int'(x.bt));
         check("cfg_ready", int'(cfg_ready_o), int'(x.rdy));
         check("tick", int'(tick_o), int'(x.tick));
         check("sq", int'(sq_o), int'(x.sq));
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic cfg(input int ch, input int dv);
      bit done = 0;
      cfg_valid_i = 1'b1;
      cfg_ch_i    = 2'(ch);
      cfg_div_i   = CW'(dv);
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk_i);
         if (cfg_ready_o) begin
            @(posedge clk_i);
            #1;
            done = 1;
         end
      end
      if (!done) begin
         miscompares++;
         $display("FAIL cfg_accept_timeout ch=%0d: got ready never high, expected acceptance", ch);
      end
      cfg_valid_i = 1'b0;
   endtask

   task automatic reset_in_pend(input int ch, input int dv);
      cfg(ch, dv);
      #1 rst_i = 1'b0;
      #1;
      check("async_rst_tick", int'(tick_o), 0);
      check("async_rst_sq", int'(sq_o), 0);
      check("async_rst_base", int'(base_tick_o), 0);
      check("async_rst_ready", int'(cfg_ready_o), 1);
      cycles(3);
      #1 rst_i = 1'b1;
   endtask

   initial begin
      #1;
      check("init_ready", int'(cfg_ready_o), 1);
      repeat (3) @(posedge clk_i);
      #2 rst_i = 1'b1;
      cycles(40);
      cfg(1, 3);
      cycles(60);
      cfg(0, 1);
      cfg(2, 2);
      cycles(40);
      cfg(1, 0);
      cycles(40);
      reset_in_pend(3, 2);
      cycles(30);
      cfg(3, 2);
      cycles(30);
      for (int i = 0; i < 25; i++) begin
         cycles($urandom_range(0, 30));
         if (i == 12) reset_in_pend(int'($urandom_range(0, 3)), int'($urandom_range(1, 5)));
         else cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
      end
      cycles(60);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
